ifetch_prefetch_queue: RTL and testbench
========================================

# ifetch_prefetch_queue

Instruction prefetch unit between the program counter and the decode pipeline register. It owns the fetch PC and issues word reads to a variable-latency instruction memory over a req/ack handshake. Returned words are buffered with their PC in a small first-word-fall-through queue that the decode stage drains. A redirect from the branch-resolution stage flushes all buffered and in-flight work.

## Interface
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, first fetch address after reset; word aligned

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mem_req  out  1  read request to instruction memory; registered
- mem_addr  out  32  word address of current request; registered, [1:0] always 0
- mem_ack  in  1  request completes this cycle; mem_rdata valid
- mem_rdata  in  32  instruction word
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0
- deq  in  1  decode consumes head entry this cycle; ignored when instr_valid=0
- instr_valid  out  1  head entry present
- instr  out  32  head instruction
- instr_pc  out  32  PC of head instruction
- pc_plus4  out  32  instr_pc + 4, mod 2^32
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- State: fetch PC `fpc`, FSM {IDLE, REQ, DROP}, circular queue of {pc, word} with rd/wr pointers and count.
- At most one request is outstanding. mem_addr = fpc while mem_req=1, held stable until mem_ack.
- IDLE: if count < DEPTH → REQ (mem_req=1 next cycle).
- REQ, mem_ack=1, no redirect: enqueue {fpc, mem_rdata}; fpc += 4; stay REQ if count_next < DEPTH, else IDLE. count_next includes this cycle's enqueue and dequeue.
- A started handshake cannot be withdrawn. REQ with redirect and mem_ack=0: flush queue; fpc ← redirect_pc; → DROP.
- DROP: mem_req stays 1 at the old address. On mem_ack, discard the word and → REQ at the new fpc.
- Redirect in DROP: update fpc only.
- Redirect in the same cycle as mem_ack in REQ: discard the word; flush; fpc ← redirect_pc; → REQ.
- Redirect in IDLE: flush; fpc ← redirect_pc; → REQ.
- Redirect wins over deq in the same cycle. Queue is empty the next cycle.
- Because fetch only proceeds with room for the in-flight word, enqueue never hits a full queue. Overflow is unreachable and must be covered by an assertion.
- deq with instr_valid=0 has no effect. Pointers wrap modulo DEPTH.
- Reset mid-handshake: all state reinitialised, and memory must tolerate an abandoned request.
- Reset values: mem_req=0, mem_addr=RESET_PC, fpc=RESET_PC, state IDLE, count=0, instr_valid=0. instr, instr_pc and pc_plus4 are don't-care while invalid.

## Timing
- Reset released at edge 0 → mem_req=1 after edge 1, addr RESET_PC.
- mem_ack in cycle t → entry visible (instr_valid=1) in cycle t+1.
- With mem_ack tied high and deq tied high: one instruction per cycle sustained, steady-state count=1.
- Redirect in cycle t → instr_valid=0 in t+1. New request starts in t+1 if no old request was in flight; otherwise the cycle after the old ack.
- deq in cycle t → next entry at head in t+1.

## Configuration
- IFQ_BYPASS_EN defined: when the queue is empty, state is REQ and mem_ack=1 with no redirect, then instr/instr_pc/pc_plus4 are driven from mem_rdata/fpc in the same cycle and instr_valid=1.
  - Bypass with deq=1: the word is not written to the queue.
  - Bypass with deq=0: the word is enqueued as usual.
  - Ack-to-valid latency becomes 0.
- IFQ_BYPASS_EN undefined: outputs come only from the queue; latency is 1 cycle.

## Test plan
- Reset, mem_ack=1, deq=0, DEPTH=4 → requests at 0x0, 0x4, 0x8, 0xC; count reaches 4; mem_req=0 afterwards. Head instr_pc=0x0, pc_plus4=0x4.
- Memory with 3-cycle ack latency, deq=1 → mem_addr held for 3 cycles each request; instr_pc sequence 0x0, 0x4, 0x8 with no duplicates.
- Redirect to 0x40 while request to 0x8 is pending (ack 2 cycles later) → word for 0x8 discarded; next mem_addr=0x40; first valid instr_pc=0x40.
- Redirect to 0x103 coinciding with mem_ack and deq → queue empty next cycle; next mem_addr=0x100.
- Queue full (count=4), deq for 4 cycles with mem_ack=1 → fetch resumes the cycle after the first deq; count never exceeds 4.
- IFQ_BYPASS_EN, empty queue, ack data 0x2402_0005 at fpc 0x20 with deq=1 → instr_valid=1, instr=0x2402_0005 in the same cycle; count stays 0.

Source files
------------

// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch unit: owns the fetch PC, issues one outstanding word read at a time
// and buffers returned words with their PC in a first-word-fall-through queue for decode.
// A redirect flushes buffered work; an in-flight read is drained and its word discarded.
// Optional build macro IFQ_BYPASS_EN: an acked word forwards straight to the outputs when the
// queue is empty, giving zero ack-to-valid latency.
module ifetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       mem_req_o,
    output logic [31:0]                mem_addr_o,
    input  logic                       mem_ack_i,
    input  logic [31:0]                mem_rdata_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    input  logic                       deq_i,
    output logic                       instr_valid_o,
    output logic [31:0]                instr_o,
    output logic [31:0]                instr_pc_o,
    output logic [31:0]                pc_plus4_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fpc_q, fpc_d;
    logic [31:0]     addr_q, addr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pc_mem_q   [DEPTH];
    logic [31:0]     word_mem_q [DEPTH];

    logic [31:0]     redirect_pc;
    logic            q_empty;
    logic            ack_req;
    logic            bypass;
    logic            enq;
    logic            deq_eff;

    assign redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;
    assign q_empty     = (count_q == '0);
    // A live (non-discarded) word returns this cycle.
    assign ack_req     = (state_q == StReq) && mem_ack_i && !redirect_i;
`ifdef IFQ_BYPASS_EN
    assign bypass      = ack_req && q_empty;
`else
    assign bypass      = 1'b0;
`endif
    // A bypassed word that decode takes immediately never touches the queue.
    assign enq         = ack_req && !(bypass && deq_i);
    assign deq_eff     = deq_i && !q_empty && !redirect_i;

    // Queue pointer and occupancy update; redirect empties the queue.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq)     wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq_eff) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(enq) - CW'(deq_eff);
        end
    end

    // Fetch FSM next state, fetch PC and request address.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        addr_d  = addr_q;
        case (state_q)
            StIdle: begin
                if (redirect_i) begin
                    fpc_d   = redirect_pc;
                    state_d = StReq;
                end else if (count_d < Full) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (redirect_i) begin
                    fpc_d   = redirect_pc;
                    // An unacked request cannot be withdrawn; wait it out in StDrop.
                    state_d = mem_ack_i ? StReq : StDrop;
                end else if (mem_ack_i) begin
                    fpc_d   = fpc_q + 32'd4;
                    state_d = (count_d < Full) ? StReq : StIdle;
                end
            end
            StDrop: begin
                if (redirect_i) fpc_d = redirect_pc;
                if (mem_ack_i)  state_d = StReq;
            end
            default: state_d = StIdle;
        endcase
        // StDrop keeps the stale address on the bus until its ack.
        if (state_d == StReq) addr_d = fpc_d;
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            fpc_q    <= RESET_PC;
            addr_q   <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            addr_q   <= addr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage; contents are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem_q[wr_ptr_q]   <= fpc_q;
            word_mem_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

    // Head-of-queue outputs, overridden by the forwarded word on bypass.
    always_comb begin
        instr_valid_o = !q_empty;
        instr_o       = word_mem_q[rd_ptr_q];
        instr_pc_o    = pc_mem_q[rd_ptr_q];
        if (bypass) begin
            instr_valid_o = 1'b1;
            instr_o       = mem_rdata_i;
            instr_pc_o    = fpc_q;
        end
    end

    assign pc_plus4_o = instr_pc_o + 32'd4;
    assign mem_req_o  = (state_q != StIdle);
    assign mem_addr_o = addr_q;
    assign count_o    = count_q;

    // Fetch only advances with room for the in-flight word, so a write into a full queue is a bug.
    assert property (@(posedge clk) disable iff (reset) !(enq && (count_q == Full)));

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Bench for ifetch_prefetch_queue: directed vector table, a slow-memory sequence and
// randomized traffic checked against a queue-based reference model.
module tb_ifetch_prefetch_queue;
    localparam int unsigned DEPTH = 4;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        deq = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    ifetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .deq_i         (deq),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .pc_plus4_o    (pc_plus4),
        .count_o       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h2402_0005;
    endfunction

    // Reference model: a queue of fetched entries plus one optional outstanding read.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_addr;
    bit          m_busy;
    bit          m_stale;

    task automatic model_reset();
        mq.delete();
        m_fpc   = 32'h0;
        m_addr  = 32'h0;
        m_busy  = 1'b0;
        m_stale = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check(input bit a, input bit r);
        bit          byp;
        bit          v;
        logic [31:0] pc;
        logic [31:0] w;
        byp = BYP && (mq.size() == 0) && m_busy && !m_stale && a && !r;
        v   = byp || (mq.size() != 0);
        pc  = byp ? m_addr : (mq.size() != 0 ? mq[0].pc : 32'h0);
        w   = byp ? memword(m_addr) : (mq.size() != 0 ? mq[0].w : 32'h0);
        chk("model mem_req", {31'h0, mem_req}, {31'h0, m_busy});
        chk("model mem_addr", mem_addr, m_addr);
        chk("model count", {29'h0, count}, mq.size());
        chk("model instr_valid", {31'h0, instr_valid}, {31'h0, v});
        if (v) begin
            chk("model instr_pc", instr_pc, pc);
            chk("model instr", instr, w);
            chk("model pc_plus4", pc_plus4, pc + 32'd4);
        end
    endtask

    task automatic model_step(input bit a, input bit r, input logic [31:0] rpc, input bit d);
        int n;
        bit byp;
        n   = mq.size();
        byp = BYP && (n == 0) && m_busy && !m_stale && a && !r;
        if (r) begin
            mq.delete();
            m_fpc = {rpc[31:2], 2'b00};
            if (m_busy && !a) begin
                m_stale = 1'b1;
            end else begin
                m_busy  = 1'b1;
                m_stale = 1'b0;
                m_addr  = m_fpc;
            end
        end else begin
            bit waiting;
            waiting = m_busy && !a;
            if (m_busy && a) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    if (!(byp && d)) mq.push_back('{m_addr, memword(m_addr)});
                    m_fpc = m_fpc + 32'd4;
                end
            end
            if (d && n > 0) void'(mq.pop_front());
            if (!waiting && !m_stale) begin
                m_busy = (mq.size() < DEPTH);
                if (m_busy) m_addr = m_fpc;
            end
        end
    endtask

    // One clock: drive at negedge, compare just after, advance the model.
    task automatic cycle(input bit a, input bit r, input logic [31:0] rpc, input bit d);
        @(negedge clk);
        mem_ack     = a;
        redirect    = r;
        redirect_pc = rpc;
        deq         = d;
        mem_rdata   = memword(m_addr);
        #1;
        model_check(a, r);
        model_step(a, r, rpc, d);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        mem_ack  = 1'b0;
        redirect = 1'b0;
        deq      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit          ack;
        bit          redir;
        bit          dq;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        int          e_cnt;
    } vec_t;

    vec_t        vt[20];
    logic [31:0] seen[$];
    int          wait_cnt;
    bit          a;
    bit          r;
    bit          d;

    initial begin
        vt[0]  = '{0, 0, 0, 32'h0,   0, 32'h0,   0,   32'h0,   0};
        vt[1]  = '{1, 0, 0, 32'h0,   1, 32'h0,   BYP, 32'h0,   0};
        vt[2]  = '{1, 0, 0, 32'h0,   1, 32'h4,   1,   32'h0,   1};
        vt[3]  = '{1, 0, 0, 32'h0,   1, 32'h8,   1,   32'h0,   2};
        vt[4]  = '{1, 0, 0, 32'h0,   1, 32'hC,   1,   32'h0,   3};
        vt[5]  = '{0, 0, 0, 32'h0,   0, 32'hC,   1,   32'h0,   4};
        vt[6]  = '{0, 0, 1, 32'h0,   0, 32'hC,   1,   32'h0,   4};
        vt[7]  = '{1, 0, 0, 32'h0,   1, 32'h10,  1,   32'h4,   3};
        vt[8]  = '{0, 0, 0, 32'h0,   0, 32'h10,  1,   32'h4,   4};
        vt[9]  = '{0, 1, 1, 32'h103, 0, 32'h10,  1,   32'h4,   4};
        vt[10] = '{0, 0, 0, 32'h0,   1, 32'h100, 0,   32'h0,   0};
        vt[11] = '{1, 0, 0, 32'h0,   1, 32'h100, BYP, 32'h100, 0};
        vt[12] = '{0, 0, 0, 32'h0,   1, 32'h104, 1,   32'h100, 1};
        vt[13] = '{0, 1, 0, 32'h40,  1, 32'h104, 1,   32'h100, 1};
        vt[14] = '{0, 0, 0, 32'h0,   1, 32'h104, 0,   32'h0,   0};
        vt[15] = '{1, 0, 0, 32'h0,   1, 32'h104, 0,   32'h0,   0};
        vt[16] = '{1, 0, 0, 32'h0,   1, 32'h40,  BYP, 32'h40,  0};
        vt[17] = '{0, 0, 0, 32'h0,   1, 32'h44,  1,   32'h40,  1};
        vt[18] = '{1, 1, 1, 32'h203, 1, 32'h44,  1,   32'h40,  1};
        vt[19] = '{0, 0, 0, 32'h0,   1, 32'h200, 0,   32'h0,   0};

        model_reset();
        do_reset();

        // Directed table: fill, stall, resume, redirects in every FSM state.
        for (int i = 0; i < 20; i++) begin
            cycle(vt[i].ack, vt[i].redir, vt[i].rpc, vt[i].dq);
            chk($sformatf("vec%0d mem_req", i), {31'h0, mem_req}, {31'h0, vt[i].e_req});
            chk($sformatf("vec%0d mem_addr", i), mem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d count", i), {29'h0, count}, vt[i].e_cnt);
            chk($sformatf("vec%0d valid", i), {31'h0, instr_valid}, {31'h0, vt[i].e_valid});
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d instr_pc", i), instr_pc, vt[i].e_pc);
                chk($sformatf("vec%0d pc_plus4", i), pc_plus4, vt[i].e_pc + 32'd4);
                chk($sformatf("vec%0d instr", i), instr, memword(vt[i].e_pc));
            end
        end

        // Slow memory (ack on third cycle of each request) with decode always draining.
        do_reset();
        wait_cnt = 0;
        seen.delete();
        for (int i = 0; i < 40 && seen.size() < 3; i++) begin
            a = m_busy && (wait_cnt == 2);
            if (m_busy) wait_cnt = a ? 0 : wait_cnt + 1;
            cycle(a, 1'b0, 32'h0, 1'b1);
            if (instr_valid) seen.push_back(instr_pc);
        end
        chk("slow seen count", seen.size(), 3);
        for (int i = 0; i < 3 && i < seen.size(); i++)
            chk($sformatf("slow pc%0d", i), seen[i], 32'(i * 4));

        // Randomized traffic with bursts of light decode demand and occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                @(negedge clk);
                do_reset();
            end else begin
                a = m_busy && ($urandom_range(0, 2) != 0);
                r = ($urandom_range(0, 24) == 0);
                d = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                         : ($urandom_range(0, 4) == 0);
                cycle(a, r, $urandom, d);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
